game_fsm: RTL and testbench
===========================

GAME_FSM -- requirements
Module: game_fsm

Interface
REQ-001 SHALL have parameter TICK_DIV, default 27000000, meaning clk cycles per timer tick (>=2).
REQ-002 SHALL have parameter GAME_HOLD_TICKS, default 3, meaning ticks W_or_L must stay decided in GAME before leaving GAME.
REQ-003 SHALL have parameter RESULT_TICKS, default 15, meaning ticks spent in WL.
REQ-004 SHALL have parameter PA_TIMEOUT_TICKS, default 30, meaning idle ticks in PA before auto-exit.
REQ-005 SHALL have parameters KEY_PWR/KEY_ST/KEY_NO/KEY_YES, defaults 10/13/14/15, meaning 5-bit key codes.
REQ-006 SHALL have port clk, input, 1 bit, meaning sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit, meaning asynchronous active-high reset.
REQ-008 SHALL have port keypad_pressed, input, 1 bit, meaning key valid level.
REQ-009 SHALL have port key, input, 5 bits, meaning key code.
REQ-010 SHALL have port W_or_L, input, 2 bits, meaning 01=lost, 10=won, 00/11=undecided.
REQ-011 SHALL have port presente, output, 3 bits, meaning current state.
REQ-012 SHALL have port result, output, 2 bits, meaning W_or_L latched on GAME->WL, held until GAME re-entered.
REQ-013 SHALL have port state_chg, output, 1 bit, meaning one-cycle pulse on the cycle after any presente change.

Function
REQ-014 SHALL encode states OFF=0, WLCM=1, CH=2, GAME=3, WL=4, PA=5; codes 6/7 SHALL recover to OFF next cycle.
REQ-015 SHALL accept a key only on the cycle keypad_pressed rises (registered edge detect); held keys SHALL act once.
REQ-016 SHALL update presente on the clk edge following acceptance (1-cycle latency).
REQ-017 KEY_PWR SHALL move any non-OFF state to OFF and OFF to WLCM.
REQ-018 KEY_ST SHALL move WLCM->CH and CH->GAME; ignored elsewhere.
REQ-019 KEY_YES SHALL move PA->GAME; KEY_NO SHALL move PA->WLCM; ignored elsewhere; unknown codes ignored.
REQ-020 Tick generator SHALL pulse tick for one cycle every TICK_DIV cycles, free-running, counter wrapping to 0.
REQ-021 In GAME, hold counter SHALL increment per tick while W_or_L is 01/10, clear to 0 on 00/11 or state exit; on reaching GAME_HOLD_TICKS SHALL go to WL.
REQ-022 In WL, counter SHALL increment per tick; on reaching RESULT_TICKS SHALL go to PA; W_or_L changes SHALL not affect WL.
REQ-023 Each state entry SHALL clear the shared tick counter; counter width SHALL be clog2 of the largest tick parameter +1, saturating, never wrapping.
REQ-024 Accepted key and timer expiry in the same cycle: key SHALL win.
REQ-025 result SHALL equal 00 until first GAME->WL transition.

Reset
REQ-026 rst SHALL asynchronously force presente=OFF, result=00, state_chg=0, all counters and edge-detect register to 0.
REQ-027 Reset mid-GAME/WL SHALL discard progress; first key after release requires a fresh rising edge.

Configuration
REQ-028 With PA_TIMEOUT_EN defined, PA SHALL auto-return to WLCM after PA_TIMEOUT_TICKS ticks without an accepted key; any accepted key SHALL restart the count.
REQ-029 Without PA_TIMEOUT_EN, PA SHALL wait indefinitely for KEY_YES/KEY_NO/KEY_PWR and PA_TIMEOUT_TICKS SHALL be unused.

Structure
REQ-030 State codes, default key codes and result encodings SHALL live in shared package game_pkg.
REQ-031 Tick generator SHALL be sub-module tick_gen (parameter TICK_DIV, ports clk, rst, tick).

Verification (TICK_DIV=4, GAME_HOLD_TICKS=3, RESULT_TICKS=2, PA_TIMEOUT_TICKS=5)
REQ-032 Power-up: rst pulse, press key 10 -> presente 0->1, state_chg one pulse; holding key 10 for 20 cycles -> no further change.
REQ-033 Flow: keys 13,13 -> presente 1->2->3; W_or_L=10 held -> WL after 3 ticks (~12 cycles), result=10, PA after 2 more ticks.
REQ-034 Glitch: in GAME W_or_L=01 for 2 ticks then 00 then 01 -> WL only 3 ticks after the second 01.
REQ-035 Priority: key 10 on the cycle WL timer expires -> presente=OFF, not PA.
REQ-036 PA: key 15 -> GAME, result kept; key 14 -> WLCM; with PA_TIMEOUT_EN and no key -> WLCM after 5 ticks; without it -> stays PA for 100 ticks.
REQ-037 Async reset asserted mid-WL between clk edges -> presente=0 immediately, counters 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game controller: state codes, default key codes
// and the encoding of the win/lose result.
package game_pkg;

    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_WLCM = 3'd1,
        S_CH   = 3'd2,
        S_GAME = 3'd3,
        S_WL   = 3'd4,
        S_PA   = 3'd5
    } state_t;

    localparam logic [4:0] KEY_PWR_DEF = 5'd10;
    localparam logic [4:0] KEY_ST_DEF  = 5'd13;
    localparam logic [4:0] KEY_NO_DEF  = 5'd14;
    localparam logic [4:0] KEY_YES_DEF = 5'd15;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_LOST = 2'b01;
    localparam logic [1:0] RES_WON  = 2'b10;

    function automatic logic is_decided(input logic [1:0] wl);
        return (wl == RES_LOST) || (wl == RES_WON);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clk cycles.
module tick_gen #(
    parameter int TICK_DIV = 27000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            if (cnt == LAST) cnt <= '0;
            else             cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/game_fsm.sv
// Game sequencing FSM: keypad navigation plus tick-timed GAME/WL/PA phases.
// Define PA_TIMEOUT_EN to let PA fall back to WLCM after PA_TIMEOUT_TICKS idle ticks.
module game_fsm
    import game_pkg::*;
#(
    parameter int TICK_DIV         = 27000000,
    parameter int GAME_HOLD_TICKS  = 3,
    parameter int RESULT_TICKS     = 15,
    parameter int PA_TIMEOUT_TICKS = 30,
    parameter logic [4:0] KEY_PWR  = KEY_PWR_DEF,
    parameter logic [4:0] KEY_ST   = KEY_ST_DEF,
    parameter logic [4:0] KEY_NO   = KEY_NO_DEF,
    parameter logic [4:0] KEY_YES  = KEY_YES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       keypad_pressed,
    input  logic [4:0] key,
    input  logic [1:0] W_or_L,
    output logic [2:0] presente,
    output logic [1:0] result,
    output logic       state_chg
);
    localparam int MAX_A = (GAME_HOLD_TICKS > RESULT_TICKS) ? GAME_HOLD_TICKS : RESULT_TICKS;
    localparam int MAX_T = (MAX_A > PA_TIMEOUT_TICKS) ? MAX_A : PA_TIMEOUT_TICKS;
    localparam int CW    = $clog2(MAX_T) + 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(GAME_HOLD_TICKS - 1);
    localparam logic [CW-1:0] RES_LAST  = CW'(RESULT_TICKS - 1);
`ifdef PA_TIMEOUT_EN
    localparam logic [CW-1:0] PA_LAST   = CW'(PA_TIMEOUT_TICKS - 1);
`endif

    state_t        state, nxt;
    logic          key_q, accept, tick;
    logic          cnt_clr, cnt_inc;
    logic [CW-1:0] cnt;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));

    assign accept   = keypad_pressed & ~key_q;
    assign presente = state;

    always_comb begin
        nxt     = state;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state)
            S_OFF, S_WLCM, S_CH: ;
            S_GAME: begin
                if (!is_decided(W_or_L)) cnt_clr = 1'b1;
                else if (tick) begin
                    if (cnt >= HOLD_LAST) nxt = S_WL;
                    else                  cnt_inc = 1'b1;
                end
            end
            S_WL: begin
                if (tick) begin
                    if (cnt >= RES_LAST) nxt = S_PA;
                    else                 cnt_inc = 1'b1;
                end
            end
            S_PA: begin
`ifdef PA_TIMEOUT_EN
                if (accept) cnt_clr = 1'b1;
                else if (tick) begin
                    if (cnt >= PA_LAST) nxt = S_WLCM;
                    else                cnt_inc = 1'b1;
                end
`endif
            end
            default: nxt = S_OFF;
        endcase

        // An accepted key overrides any timer expiry in the same cycle.
        if (accept) begin
            if (key == KEY_PWR) begin
                nxt = (state == S_OFF) ? S_WLCM : S_OFF;
            end else if (key == KEY_ST) begin
                if (state == S_WLCM)    nxt = S_CH;
                else if (state == S_CH) nxt = S_GAME;
            end else if (key == KEY_YES && state == S_PA) begin
                nxt = S_GAME;
            end else if (key == KEY_NO && state == S_PA) begin
                nxt = S_WLCM;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_OFF;
            key_q     <= 1'b0;
            cnt       <= '0;
            result    <= RES_NONE;
            state_chg <= 1'b0;
        end else begin
            key_q     <= keypad_pressed;
            state     <= nxt;
            state_chg <= (nxt != state);
            if (nxt != state || cnt_clr) cnt <= '0;
            else if (cnt_inc && cnt != '1) cnt <= cnt + 1'b1;
            if (state == S_GAME && nxt == S_WL) result <= W_or_L;
        end
    end
endmodule

// File: tb/tb_game_fsm.sv
// Directed bench for game_fsm with a short tick period; tick timing is modelled
// from the number of clk edges since reset release.
module tb_game_fsm;
    logic       clk = 1'b0;
    logic       rst;
    logic       keypad_pressed;
    logic [4:0] key;
    logic [1:0] W_or_L;
    logic [2:0] presente;
    logic [1:0] result;
    logic       state_chg;

    int n_tests = 0;
    int n_fail  = 0;
    int ecnt    = 0;
    int chg_sum;

    game_fsm #(
        .TICK_DIV(4), .GAME_HOLD_TICKS(3), .RESULT_TICKS(2), .PA_TIMEOUT_TICKS(5)
    ) dut (
        .clk(clk), .rst(rst), .keypad_pressed(keypad_pressed), .key(key),
        .W_or_L(W_or_L), .presente(presente), .result(result), .state_chg(state_chg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    // tick is high in the current cycle when a multiple of 4 edges have elapsed
    function automatic bit tick_now();
        return (ecnt > 0) && (ecnt % 4 == 0);
    endfunction

    task automatic wait_ticks(input int n);
        int c = 0;
        while (c < n) begin
            if (tick_now()) c++;
            step();
        end
    endtask

    task automatic press(input logic [4:0] k);
        key = k;
        keypad_pressed = 1'b1;
        step();
        keypad_pressed = 1'b0;
        step();
    endtask

    task automatic to_game();
        press(5'd10);
        press(5'd13);
        press(5'd13);
    endtask

    initial begin
        rst = 1'b1;
        keypad_pressed = 1'b0;
        key = 5'd0;
        W_or_L = 2'b00;
        #12;
        check("rst_presente", presente, 0);
        check("rst_result", result, 0);
        check("rst_chg", state_chg, 0);
        @(negedge clk);
        rst = 1'b0;
        ecnt = 0;
        step();

        // power-up and held key acting once
        key = 5'd10;
        keypad_pressed = 1'b1;
        step();
        check("pwr_on", presente, 1);
        check("chg_pulse", state_chg, 1);
        chg_sum = 0;
        repeat (20) begin
            step();
            chg_sum += state_chg;
        end
        check("hold_once", presente, 1);
        check("hold_no_chg", chg_sum, 0);
        keypad_pressed = 1'b0;
        step();

        press(5'd7);
        check("bad_key", presente, 1);
        press(5'd15);
        check("yes_ignored", presente, 1);

        press(5'd13);
        check("st_to_ch", presente, 2);
        press(5'd13);
        check("st_to_game", presente, 3);
        press(5'd13);
        check("st_in_game", presente, 3);

        // won held: WL on third tick, PA two ticks later
        W_or_L = 2'b10;
        wait_ticks(2);
        check("game_hold2", presente, 3);
        check("result_pre", result, 0);
        wait_ticks(1);
        check("to_wl", presente, 4);
        check("result_won", result, 2);
        W_or_L = 2'b01;
        wait_ticks(1);
        check("wl_1tick", presente, 4);
        wait_ticks(1);
        check("to_pa", presente, 5);
        check("result_pa", result, 2);

        W_or_L = 2'b00;
        press(5'd15);
        check("yes_to_game", presente, 3);
        check("result_kept", result, 2);

        // glitch to undecided restarts the hold count
        W_or_L = 2'b01;
        wait_ticks(2);
        check("glitch_a", presente, 3);
        W_or_L = 2'b00;
        wait_ticks(1);
        check("glitch_clr", presente, 3);
        W_or_L = 2'b01;
        wait_ticks(2);
        check("glitch_b", presente, 3);
        wait_ticks(1);
        check("glitch_wl", presente, 4);
        check("result_lost", result, 1);

        // power key coincides with WL expiry
        wait_ticks(1);
        while (!tick_now()) step();
        key = 5'd10;
        keypad_pressed = 1'b1;
        step();
        check("pwr_wins", presente, 0);
        keypad_pressed = 1'b0;
        step();

        W_or_L = 2'b00;
        to_game();
        W_or_L = 2'b10;
        wait_ticks(3);
        check("wl_again", presente, 4);
        W_or_L = 2'b00;
        wait_ticks(2);
        check("pa_again", presente, 5);
        press(5'd14);
        check("no_to_wlcm", presente, 1);

        press(5'd10);
        to_game();
        W_or_L = 2'b10;
        wait_ticks(3);
        W_or_L = 2'b00;
        wait_ticks(2);
        check("pa_third", presente, 5);
`ifdef PA_TIMEOUT_EN
        key = 5'd7;
        keypad_pressed = 1'b1;
        step();
        keypad_pressed = 1'b0;
        wait_ticks(4);
        check("pa_wait4", presente, 5);
        wait_ticks(1);
        check("pa_timeout", presente, 1);
        press(5'd10);
`else
        wait_ticks(100);
        check("pa_no_timeout", presente, 5);
`endif

        // async reset in WL
        press(5'd10);
        to_game();
        W_or_L = 2'b10;
        wait_ticks(3);
        check("wl_before_rst", presente, 4);
        #2;
        rst = 1'b1;
        #1;
        check("arst_presente", presente, 0);
        check("arst_result", result, 0);
        check("arst_chg", state_chg, 0);
        check("arst_cnt", 32'(dut.cnt), 0);
        W_or_L = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        ecnt = 0;
        press(5'd10);
        check("post_rst_pwr", presente, 1);
        press(5'd13);
        press(5'd13);
        W_or_L = 2'b10;
        wait_ticks(2);
        check("post_rst_hold", presente, 3);
        wait_ticks(1);
        check("post_rst_wl", presente, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
